// File: rtl/cache_ctrl_pkg.sv
// Shared widths, FSM state encoding and CPU address field helpers for the
// direct-mapped write-through cache controller.
package cache_ctrl_pkg;

    localparam int IDX    = 6;
    localparam int OFS    = 2;
    localparam int WORD   = 32;
    localparam int NWORDS = 1 << OFS;
    localparam int BLK    = WORD << OFS;
    localparam int DEP    = 1 << IDX;
    localparam int TAG    = 32 - IDX - OFS - 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_MEM_RD = 3'd2,
        ST_REFILL = 3'd3,
        ST_MEM_WR = 3'd4
    } state_t;

    function automatic logic [OFS-1:0] addr_off(input logic [31:0] a);
        return a[OFS+1:2];
    endfunction

    function automatic logic [IDX-1:0] addr_idx(input logic [31:0] a);
        return a[IDX+OFS+1:OFS+2];
    endfunction

    function automatic logic [TAG-1:0] addr_tag(input logic [31:0] a);
        return a[31:IDX+OFS+2];
    endfunction

    // Block-aligned byte address used for refill reads.
    function automatic logic [31:0] addr_blk(input logic [31:0] a);
        return {a[31:OFS+2], {(OFS+2){1'b0}}};
    endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// CPU load/store port and memory bus of the cache controller. The slave
// modport is the controller's view; master is the CPU/memory environment.
interface cache_ctrl_if;
    import cache_ctrl_pkg::*;

    logic            cpu_req;
    logic            cpu_we;
    logic [31:0]     cpu_addr;
    logic [WORD-1:0] cpu_wdata;
    logic [WORD-1:0] cpu_rdata;
    logic            cpu_ready;

    logic            mem_req;
    logic            mem_we;
    logic [31:0]     mem_addr;
    logic [WORD-1:0] mem_wdata;
    logic [BLK-1:0]  mem_rdata;
    logic            mem_ready;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
        output cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
        input  cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/cache_ctrl_ram_tag.sv
// Tag/valid store: DEP entries of TAG bits plus a valid bit, combinational
// read, single write port, valid bits cleared synchronously on reset.
module cache_ctrl_ram_tag
    import cache_ctrl_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    input  logic [IDX-1:0] rd_idx,
    output logic [TAG-1:0] rd_tag,
    output logic           rd_valid,
    input  logic           wr_en,
    input  logic [IDX-1:0] wr_idx,
    input  logic [TAG-1:0] wr_tag
);

    logic [TAG-1:0] tag_mem [DEP];
    logic [DEP-1:0] valid_reg;

    // Tags need no reset: a line is only trusted once its valid bit is set.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            tag_mem[wr_idx] <= wr_tag;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEP; gi++) begin : g_valid
            always_ff @(posedge clock) begin
                if (reset) begin
                    valid_reg[gi] <= 1'b0;
                end else if (wr_en && wr_idx == IDX'(gi)) begin
                    valid_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    assign rd_tag   = tag_mem[rd_idx];
    assign rd_valid = valid_reg[rd_idx];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller: lookup and
// refill FSM, word select for loads and word merge for store hits.
module cache_ctrl
    import cache_ctrl_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    cache_ctrl_if.slave     bus,
    output logic [IDX-1:0]  ram_index,
    output logic [OFS-1:0]  ram_offset,
    output logic [BLK-1:0]  ram_data_in,
    input  logic [BLK-1:0]  ram_data_out,
    output logic            ram_write
);

    state_t          state_reg;
    logic [31:0]     addr_reg;
    logic            we_reg;
    logic [WORD-1:0] wdata_reg;
    logic [BLK-1:0]  blk_reg;

    logic [IDX-1:0]  idx_q;
    logic [OFS-1:0]  off_q;
    logic [TAG-1:0]  tag_q;

    assign idx_q = addr_idx(addr_reg);
    assign off_q = addr_off(addr_reg);
    assign tag_q = addr_tag(addr_reg);

    logic [TAG-1:0]  tag_rd;
    logic            valid_rd;
    logic            tag_we;
    logic            hit;

    assign tag_we = !reset && (state_reg == ST_REFILL);
    assign hit    = valid_rd && (tag_rd == tag_q);

    cache_ctrl_ram_tag u_ram_tag (
        .clock    (clock),
        .reset    (reset),
        .rd_idx   (idx_q),
        .rd_tag   (tag_rd),
        .rd_valid (valid_rd),
        .wr_en    (tag_we),
        .wr_idx   (idx_q),
        .wr_tag   (tag_q)
    );

    logic [WORD-1:0] ram_words [NWORDS];
    logic [BLK-1:0]  merged;

    genvar gi;
    generate
        for (gi = 0; gi < NWORDS; gi++) begin : g_word
            assign ram_words[gi] = ram_data_out[gi*WORD +: WORD];
            assign merged[gi*WORD +: WORD] = (off_q == OFS'(gi)) ? wdata_reg
                                                                 : ram_data_out[gi*WORD +: WORD];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            we_reg    <= 1'b0;
            wdata_reg <= '0;
            blk_reg   <= '0;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (bus.cpu_req) begin
                        addr_reg  <= bus.cpu_addr;
                        we_reg    <= bus.cpu_we;
                        wdata_reg <= bus.cpu_wdata;
                        state_reg <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    // Stores always go to memory; only load misses refill.
                    if (we_reg) begin
                        state_reg <= ST_MEM_WR;
                    end else if (hit) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        state_reg <= ST_MEM_RD;
                    end
                end
                ST_MEM_RD: begin
                    if (bus.mem_ready) begin
                        blk_reg   <= bus.mem_rdata;
                        state_reg <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    state_reg <= ST_LOOKUP;
                end
                ST_MEM_WR: begin
                    if (bus.mem_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode from state and inputs; reset overrides everything.
    always_comb begin
        bus.cpu_rdata = '0;
        bus.cpu_ready = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        ram_index     = '0;
        ram_offset    = '0;
        ram_data_in   = '0;
        ram_write     = 1'b0;
        if (!reset) begin
            ram_index  = idx_q;
            ram_offset = off_q;
            unique case (state_reg)
                ST_IDLE: begin
                    // Start the RAM read on the accepting edge for 1-cycle hits.
                    ram_index = addr_idx(bus.cpu_addr);
                end
                ST_LOOKUP: begin
                    if (hit && !we_reg) begin
                        bus.cpu_ready = 1'b1;
                        bus.cpu_rdata = ram_words[off_q];
                    end else if (hit && we_reg) begin
                        ram_write   = 1'b1;
                        ram_data_in = merged;
                    end
                end
                ST_MEM_RD: begin
                    bus.mem_req  = 1'b1;
                    bus.mem_addr = addr_blk(addr_reg);
                end
                ST_REFILL: begin
                    ram_write   = 1'b1;
                    ram_data_in = blk_reg;
                end
                ST_MEM_WR: begin
                    bus.mem_req   = 1'b1;
                    bus.mem_we    = 1'b1;
                    bus.mem_addr  = addr_reg;
                    bus.mem_wdata = wdata_reg;
                    bus.cpu_ready = bus.mem_ready;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: transaction table plus hand-written sequences
// for immediate mem_ready and reset during a refill read.
module tb_cache_ctrl;
    import cache_ctrl_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    cache_ctrl_if bus();

    logic [IDX-1:0] ram_index;
    logic [OFS-1:0] ram_offset;
    logic [BLK-1:0] ram_data_in;
    logic [BLK-1:0] ram_data_out;
    logic           ram_write;

    cache_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus),
        .ram_index    (ram_index),
        .ram_offset   (ram_offset),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out),
        .ram_write    (ram_write)
    );

    // Data RAM model: registered read, write-first so a refill is visible next cycle.
    logic [BLK-1:0] dram [DEP];
    initial begin
        for (int i = 0; i < DEP; i++) dram[i] = '0;
        ram_data_out = '0;
    end
    always @(posedge clock) begin
        if (ram_write) dram[ram_index] <= ram_data_in;
        ram_data_out <= ram_write ? ram_data_in : dram[ram_index];
    end

    // Main memory: default word value is 0xC000_0000 | address, overridden by writes.
    logic [31:0] backing [logic [31:0]];
    int          mem_delay;
    int          mem_cnt;
    int          n_rd;
    int          n_wr;
    logic [31:0] last_maddr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (backing.exists(a)) return backing[a];
        return 32'hC000_0000 | a;
    endfunction

    // mem_ready rises at the negedge of the mem_delay-th consecutive mem_req cycle.
    always @(negedge clock) begin
        if (reset || bus.mem_ready) begin
            bus.mem_ready = 1'b0;
            mem_cnt = 0;
        end else if (bus.mem_req) begin
            mem_cnt++;
            if (mem_cnt >= mem_delay) begin
                bus.mem_ready = 1'b1;
                last_maddr = bus.mem_addr;
                if (bus.mem_we) begin
                    n_wr++;
                    backing[bus.mem_addr] = bus.mem_wdata;
                end else begin
                    n_rd++;
                    for (int w = 0; w < NWORDS; w++)
                        bus.mem_rdata[w*WORD +: WORD] = mem_word(bus.mem_addr + 32'(4*w));
                end
            end
        end else begin
            mem_cnt = 0;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one access; lat = count of cycles after the accepting edge until cpu_ready.
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             output int lat, output logic [31:0] rdata, output int ramwr,
                             output int first_ramwr, output logic quiet);
        @(negedge clock);
        #1;
        quiet = !bus.cpu_ready && !bus.mem_req && !ram_write;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        lat = -1;
        rdata = '0;
        ramwr = 0;
        first_ramwr = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clock);
            #1;
            if (ram_write) begin
                ramwr++;
                if (first_ramwr < 0) first_ramwr = k;
            end
            if (bus.cpu_ready) begin
                lat = k;
                rdata = bus.cpu_rdata;
                break;
            end
        end
        bus.cpu_req = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_rdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        int          exp_ramwr;
        logic [31:0] exp_maddr;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    initial begin
        int          lat, ramwr, first_ramwr, rd0, wr0;
        logic [31:0] rdata;
        logic        quiet;

        // mem_delay = 2: load miss latency 5 (LOOKUP, MEM_RD x2, REFILL, LOOKUP), store 3.
        vecs[0]  = '{1'b0, 32'h0000_0040, 32'h0,         1'b1, 32'hC000_0040, 5, 1, 0, 1, 32'h0000_0040};
        vecs[1]  = '{1'b0, 32'h0000_0044, 32'h0,         1'b1, 32'hDEAD_BEEF, 1, 0, 0, 0, 32'h0};
        vecs[2]  = '{1'b1, 32'h0000_0044, 32'h1234_5678, 1'b0, 32'h0,         3, 0, 1, 1, 32'h0000_0044};
        vecs[3]  = '{1'b0, 32'h0000_0044, 32'h0,         1'b1, 32'h1234_5678, 1, 0, 0, 0, 32'h0};
        vecs[4]  = '{1'b0, 32'h0000_0048, 32'h0,         1'b1, 32'hC000_0048, 1, 0, 0, 0, 32'h0};
        vecs[5]  = '{1'b1, 32'h0000_0800, 32'hCAFE_F00D, 1'b0, 32'h0,         3, 0, 1, 0, 32'h0000_0800};
        vecs[6]  = '{1'b0, 32'h0000_0800, 32'h0,         1'b1, 32'hCAFE_F00D, 5, 1, 0, 1, 32'h0000_0800};
        vecs[7]  = '{1'b0, 32'h0000_004C, 32'h0,         1'b1, 32'hC000_004C, 1, 0, 0, 0, 32'h0};
        vecs[8]  = '{1'b0, 32'h0000_0440, 32'h0,         1'b1, 32'hC000_0440, 5, 1, 0, 1, 32'h0000_0440};
        vecs[9]  = '{1'b0, 32'h0000_0044, 32'h0,         1'b1, 32'h1234_5678, 5, 1, 0, 1, 32'h0000_0040};
        vecs[10] = '{1'b0, 32'h0000_080C, 32'h0,         1'b1, 32'hC000_080C, 1, 0, 0, 0, 32'h0};
        vecs[11] = '{1'b1, 32'h0000_0448, 32'h0BAD_C0DE, 1'b0, 32'h0,         3, 0, 1, 0, 32'h0000_0448};

        backing[32'h0000_0044] = 32'hDEAD_BEEF;
        mem_delay = 2;
        mem_cnt = 0;
        n_rd = 0;
        n_wr = 0;
        last_maddr = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;

        // Reset with a pending request: every output must stay low.
        reset = 1'b1;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 32'h0000_03F0;
        bus.cpu_wdata = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst cpu_ready", 32'(bus.cpu_ready), 32'd0);
        chk("rst mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst mem_addr", bus.mem_addr, 32'd0);
        chk("rst ram_write", 32'(ram_write), 32'd0);
        chk("rst ram_index", 32'(ram_index), 32'd0);
        chk("rst ram_offset", 32'(ram_offset), 32'd0);
        @(negedge clock);
        bus.cpu_req = 1'b0;
        reset = 1'b0;
        #1;
        chk("idle ram_index", 32'(ram_index), 32'h3F);
        $display("reset done");

        for (int i = 0; i < NV; i++) begin
            rd0 = n_rd;
            wr0 = n_wr;
            do_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rdata, ramwr, first_ramwr, quiet);
            $display("txn %0d %s addr=%h lat=%0d rdata=%h mem_rd=%0d mem_wr=%0d ram_wr=%0d",
                     i, vecs[i].we ? "store" : "load", vecs[i].addr, lat, rdata,
                     n_rd - rd0, n_wr - wr0, ramwr);
            chk($sformatf("txn%0d idle_quiet", i), 32'(quiet), 32'd1);
            chk($sformatf("txn%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            if (vecs[i].chk_rdata)
                chk($sformatf("txn%0d rdata", i), rdata, vecs[i].exp_rdata);
            chk($sformatf("txn%0d mem_reads", i), 32'(n_rd - rd0), 32'(vecs[i].exp_rd));
            chk($sformatf("txn%0d mem_writes", i), 32'(n_wr - wr0), 32'(vecs[i].exp_wr));
            chk($sformatf("txn%0d ram_writes", i), 32'(ramwr), 32'(vecs[i].exp_ramwr));
            if (vecs[i].exp_rd + vecs[i].exp_wr > 0)
                chk($sformatf("txn%0d mem_addr", i), last_maddr, vecs[i].exp_maddr);
        end

        // mem_ready in the first mem_req cycle: REFILL at cycle 3, cpu_ready at cycle 4.
        mem_delay = 1;
        rd0 = n_rd;
        do_access(1'b0, 32'h0000_1000, 32'h0, lat, rdata, ramwr, first_ramwr, quiet);
        $display("txn fast load addr=00001000 lat=%0d rdata=%h refill_cycle=%0d", lat, rdata, first_ramwr);
        chk("fast latency", 32'(lat), 32'd4);
        chk("fast refill_cycle", 32'(first_ramwr), 32'd3);
        chk("fast rdata", rdata, 32'hC000_1000);
        chk("fast mem_reads", 32'(n_rd - rd0), 32'd1);
        chk("fast mem_addr", last_maddr, 32'h0000_1000);

        // Reset while MEM_RD waits on memory: the read is abandoned.
        mem_delay = 1000;
        @(negedge clock);
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 32'h0000_2040;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            #1;
            if (bus.mem_req) begin
                lat = k;
                break;
            end
        end
        chk("rstmid mem_req_cycle", 32'(lat), 32'd2);
        chk("rstmid mem_addr", bus.mem_addr, 32'h0000_2040);
        bus.cpu_req = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        $display("txn reset-in-MEM_RD mem_req_after=%0d", bus.mem_req);
        chk("rstmid mem_req_after", 32'(bus.mem_req), 32'd0);
        chk("rstmid cpu_ready_after", 32'(bus.cpu_ready), 32'd0);
        chk("rstmid ram_write_after", 32'(ram_write), 32'd0);

        // Line 4 held 0x40 before reset; with valid cleared it must miss.
        mem_delay = 2;
        rd0 = n_rd;
        do_access(1'b0, 32'h0000_0040, 32'h0, lat, rdata, ramwr, first_ramwr, quiet);
        $display("txn post-reset load addr=00000040 lat=%0d rdata=%h", lat, rdata);
        chk("postrst latency", 32'(lat), 32'd5);
        chk("postrst rdata", rdata, 32'hC000_0040);
        chk("postrst mem_reads", 32'(n_rd - rd0), 32'd1);

        rd0 = n_rd;
        do_access(1'b0, 32'h0000_0044, 32'h0, lat, rdata, ramwr, first_ramwr, quiet);
        $display("txn post-reset load addr=00000044 lat=%0d rdata=%h", lat, rdata);
        chk("postrst2 latency", 32'(lat), 32'd1);
        chk("postrst2 rdata", rdata, 32'h1234_5678);
        chk("postrst2 mem_reads", 32'(n_rd - rd0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
